// File: rtl/maint_fetch_sequencer_pkg.sv
// Shared constants for the maintenance fetch sequencer: opcode field and FSM encodings.
package maint_fetch_sequencer_pkg;

  localparam int unsigned OPC_LSB       = 60;
  localparam logic [3:0]  END_OPC       = 4'hF;
  localparam int unsigned GRANT_TIMEOUT = 16;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StGrant = 3'd1;
  localparam logic [2:0] StFetch = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StProg  = 3'd4;

endpackage

// File: rtl/maint_fetch_sequencer_instr_fifo.sv
// Synchronous instruction buffer with registered storage and an occupancy count.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, empty, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only safe when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      assert (!(push && full && !do_pop))
        else $error("instr_fifo: push while full");
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = !empty;
  assign count = count_q;

endmodule

// File: rtl/maint_fetch_sequencer.sv
// Arbitrates host programs against maintenance routines and streams routine ROM words to the
// executor through a credit-limited instruction buffer.
module maint_fetch_sequencer
  import maint_fetch_sequencer_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter int unsigned INSTR_WIDTH     = 64,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_ADDR        = 127
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       maint_req,
  output logic                       maint_ack,
  input  logic                       maint_process,
  input  logic                       prog_req,
  output logic                       prog_grant,
  input  logic                       prog_done,
  output logic                       program_process,
  output logic [IMEM_ADDR_WIDTH-1:0] in_addr,
  output logic                       in_valid,
  input  logic [INSTR_WIDTH-1:0]     out_data,
  input  logic                       out_valid,
  output logic                       softmc_fin,
  output logic [INSTR_WIDTH-1:0]     ex_instr,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  input  logic                       ex_idle,
  output logic                       overrun_err
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OccW   = CntW + 1;
  localparam int unsigned TimerW = $clog2(GRANT_TIMEOUT);
  localparam logic [IMEM_ADDR_WIDTH-1:0] MaxAddr = IMEM_ADDR_WIDTH'(MAX_ADDR);

  logic [2:0]                 state_q, state_d;
  logic [IMEM_ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
  logic [TimerW-1:0]          timer_q, timer_d;
  logic [1:0]                 inflight_q, inflight_d;
  logic                       end_seen_q, end_seen_d;
  logic                       overrun_q, overrun_d;
  logic                       ack_q, ack_d;
  logic                       fin_q, fin_d;

  logic [CntW-1:0] fifo_count;
  logic [OccW-1:0] occupancy;
  logic            fifo_valid, is_end, credit, issue, ret, push, pop;

  assign is_end    = (out_data[OPC_LSB +: 4] == END_OPC);
  assign occupancy = {1'b0, fifo_count} + OccW'(inflight_q);
  assign credit    = (occupancy < OccW'(FIFO_DEPTH));
  // Returning END blocks the same-cycle fetch so nothing lands after the routine's end.
  assign issue     = (state_q == StFetch) && credit && !(out_valid && is_end);
  assign ret       = out_valid && (inflight_q != 2'd0);
  // After an overrun the words already in flight are still real routine content.
  assign push      = ret && !is_end &&
                     ((state_q == StFetch) || ((state_q == StDrain) && !end_seen_q));
  assign pop       = fifo_valid && ex_ready;

  assign inflight_d = inflight_q + 2'(issue) - 2'(ret);

  always_comb begin
    state_d    = state_q;
    in_addr_d  = in_addr_q;
    timer_d    = timer_q;
    end_seen_d = end_seen_q;
    overrun_d  = overrun_q;
    ack_d      = 1'b0;
    fin_d      = 1'b0;
    if (issue) in_addr_d = in_addr_q + IMEM_ADDR_WIDTH'(1);
    case (state_q)
      StIdle: begin
        if (maint_req) begin
          ack_d   = 1'b1;
          timer_d = '0;
          state_d = StGrant;
        end else if (prog_req) begin
          state_d = StProg;
        end
      end
      StGrant: begin
        if (maint_process) begin
          in_addr_d  = '0;
          end_seen_d = 1'b0;
          state_d    = StFetch;
        end else if (timer_q == TimerW'(GRANT_TIMEOUT - 1)) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StFetch: begin
        if (out_valid && is_end) begin
          end_seen_d = 1'b1;
          state_d    = StDrain;
        end else if (issue && (in_addr_q == MaxAddr)) begin
          overrun_d = 1'b1;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        if (!fifo_valid && ex_idle && (inflight_q == 2'd0)) begin
          fin_d     = 1'b1;
          in_addr_d = '0;
          state_d   = StIdle;
        end
      end
      StProg: begin
        if (prog_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      in_addr_q  <= '0;
      timer_q    <= '0;
      inflight_q <= '0;
      end_seen_q <= 1'b0;
      overrun_q  <= 1'b0;
      ack_q      <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_addr_q  <= in_addr_d;
      timer_q    <= timer_d;
      inflight_q <= inflight_d;
      end_seen_q <= end_seen_d;
      overrun_q  <= overrun_d;
      ack_q      <= ack_d;
      fin_q      <= fin_d;
    end
  end

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (out_data),
    .pop       (pop),
    .head      (ex_instr),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign in_valid        = issue;
  assign in_addr         = in_addr_q;
  assign maint_ack       = ack_q;
  assign softmc_fin      = fin_q;
  assign prog_grant      = (state_q == StProg);
  assign program_process = prog_grant;
  assign ex_valid        = fifo_valid;
  assign overrun_err     = overrun_q;

endmodule

// File: doc/maint_fetch_sequencer.md
Name: maint_fetch_sequencer

Overview:
- Sits between the maintenance controller and the instruction execution pipeline.
- Arbitrates between host-issued user programs and maintenance requests (periodic read, ZQ, refresh).
- For a granted maintenance routine, it walks the routine's ROM address space and buffers the returned instructions in a small FIFO for the executor.
- Detects the END instruction and, once the executor drains, returns softmc_fin to close the routine.

Parameters:
IMEM_ADDR_WIDTH, 10, width of in_addr (matches `IMEM_ADDR_WIDTH)
INSTR_WIDTH, 64, instruction word width (matches `INSTR_WIDTH)
OPC_LSB, 60, LSB of 4-bit opcode field in an instruction
END_OPC, 4'hF, opcode value marking routine end
FIFO_DEPTH, 4, instruction buffer entries (power of two, >=2)
MAX_ADDR, 127, last fetchable routine address (largest maintenance ROM)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
maint_req  in  1  maintenance controller requests service
maint_ack  out  1  one-cycle grant pulse to maintenance controller
maint_process  in  1  maintenance controller has latched the grant
prog_req  in  1  host requests a user-program run (level, held until prog_done)
prog_grant  out  1  level: user program owns the executor
prog_done  in  1  one-cycle pulse from program engine at program end
program_process  out  1  equals prog_grant; feeds maintenance timers
in_addr  out  IMEM_ADDR_WIDTH  maintenance ROM fetch address
in_valid  out  1  fetch strobe
out_data  in  INSTR_WIDTH  ROM read data, valid one cycle after in_valid
out_valid  in  1  qualifies out_data
softmc_fin  out  1  one-cycle pulse: maintenance routine complete
ex_instr  out  INSTR_WIDTH  FIFO head to executor
ex_valid  out  1  FIFO non-empty
ex_ready  in  1  executor accepts head when ex_valid && ex_ready
ex_idle  in  1  executor has no instruction in flight
overrun_err  out  1  sticky: address passed MAX_ADDR without END

Behaviour:
- Reset (rst==0 at posedge):
  - State IDLE; all outputs 0; in_addr=0; FIFO empty; counters cleared.
  - overrun_err is cleared only by reset.
- States:
  - IDLE:
    - maint_req=1 -> pulse maint_ack for one cycle, go to GRANT.
    - Else prog_req=1 -> set prog_grant, go to PROG.
    - Both asserted in the same cycle -> maintenance wins.
  - GRANT:
    - Wait for maint_process=1, then go to FETCH with in_addr=0.
    - Timeout of 16 cycles without maint_process -> return to IDLE (no fin).
  - FETCH:
    - Assert in_valid when count + inflight < FIFO_DEPTH; in_addr increments by 1 after each issued fetch.
    - Each out_valid pushes out_data into the FIFO; inflight counts issued fetches not yet returned (max 1 per cycle, 1-cycle latency).
    - Pushed opcode == END_OPC -> stop issuing, go to DRAIN. The END word itself is not pushed.
    - Fetch issued at in_addr == MAX_ADDR with no END -> set overrun_err, stop issuing, go to DRAIN.
  - DRAIN:
    - Discard any fetches still returning after END.
    - When FIFO is empty and ex_idle=1 -> pulse softmc_fin for exactly one cycle, go to IDLE.
  - PROG:
    - prog_grant/program_process held high; in_valid=0; maint_req is ignored (never preempts).
    - prog_done -> drop prog_grant next cycle, go to IDLE.
    - A pending maint_req is then granted before a still-asserted prog_req.
- FIFO:
  - Push and pop in the same cycle are legal and leave count unchanged.
  - Push when full cannot occur by credit rule; assert in simulation.
  - Pointers wrap modulo FIFO_DEPTH.
  - ex_instr is the registered head.
- softmc_fin, maint_ack and prog_grant are never high together.
- Reset asserted mid-routine: abandons FETCH/DRAIN immediately, with no softmc_fin.

Decomposition:
- Shared package/header (parameters.vh additions): END_OPC, OPC_LSB, and state encodings IDLE/GRANT/FETCH/DRAIN/PROG.
- One sub-module: instr_fifo (parameterised depth/width, sync, registered head, count output).

Test Plan:
- maint_req=1 from IDLE, maint_process 1 cycle later, ROM words 0..2 normal and word 3 END:
  - in_addr drives 0,1,2,3 and then stops.
  - ex_instr delivers exactly 3 words.
  - softmc_fin pulses once, 1 cycle after FIFO empty and ex_idle=1.
- maint_req and prog_req rise in the same cycle -> maint_ack pulses and prog_grant stays 0 until after softmc_fin.
- prog_grant active and maint_req raised -> no maint_ack until the cycle after prog_done; then maint_ack within 1 cycle.
- ex_ready held 0 with an 8-word routine and FIFO_DEPTH=4 -> in_valid stops after 4 fetches, FIFO count=4, no overflow; releasing ex_ready resumes fetching at in_addr=4.
- ROM with no END through address 127 -> overrun_err=1 after the fetch at 127, and softmc_fin still pulses after drain.
- rst=0 during FETCH at in_addr=5 -> next cycle state IDLE, ex_valid=0, in_addr=0, no softmc_fin.
